// File: rtl/cic3_row_readout.sv
// cic3_row_readout: snapshots the CIC3 filter row outputs on a decimated
// sample strobe and streams the enabled channels as (channel, word) beats
// over a valid/ready interface. Flags strobes that arrive mid-frame.
module cic3_row_readout #(
  parameter int unsigned NUM_FILTERS = 24,
  parameter int unsigned WORD_WIDTH  = 25,
  parameter int unsigned CH_WIDTH    = 5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              sample,
  input  logic [NUM_FILTERS*WORD_WIDTH-1:0] filt_in,
  input  logic [NUM_FILTERS-1:0]            ch_mask,
  output logic [WORD_WIDTH-1:0]             dout_data,
  output logic [CH_WIDTH-1:0]               dout_ch,
  output logic                              dout_valid,
  input  logic                              dout_ready,
  output logic                              dout_first,
  output logic                              dout_last,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              clr_overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                              state;
  logic [NUM_FILTERS*WORD_WIDTH-1:0]   shadow;
  logic [NUM_FILTERS-1:0]              pend_mask;

  logic                                handshake;
  logic                                final_hs;
  logic                                capture;
  logic                                drop;
  logic [NUM_FILTERS-1:0]              mask_after_hs;
  logic [NUM_FILTERS-1:0]              next_mask;
  logic [NUM_FILTERS*WORD_WIDTH-1:0]   next_src;
  logic [CH_WIDTH-1:0]                 next_sel;
  logic                                next_found;
  logic                                next_single;
  state_t                              next_state;

  // Next-frame bookkeeping. The output beat is precomputed from the mask the
  // FSM will hold next cycle, so dout_* can be registered while still giving
  // one beat per cycle and a zero-gap frame turnover on the final handshake.
  always_comb begin
    handshake     = dout_valid & dout_ready;
    final_hs      = handshake & dout_last;
    capture       = sample & (|ch_mask) & ((state == IDLE) | final_hs);
    drop          = sample & (state == SEND) & ~final_hs;
    mask_after_hs = handshake ? (pend_mask & ~(NUM_FILTERS'(1) << dout_ch))
                              : pend_mask;
    next_mask     = capture ? ch_mask : mask_after_hs;
    next_src      = capture ? filt_in : shadow;
    next_single   = (next_mask != '0) &&
                    ((next_mask & (next_mask - NUM_FILTERS'(1))) == '0);

    next_sel   = '0;
    next_found = 1'b0;
    for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
      if (!next_found && next_mask[i]) begin
        next_sel   = CH_WIDTH'(i);
        next_found = 1'b1;
      end
    end

    next_state = state;
    if (capture)       next_state = SEND;
    else if (final_hs) next_state = IDLE;
  end

  // FSM, shadow capture, registered beat outputs and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shadow     <= '0;
      pend_mask  <= '0;
      dout_data  <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= (next_state == SEND);
      pend_mask  <= next_mask;
      if (capture) shadow <= filt_in;
      dout_valid <= (next_state == SEND);
      dout_ch    <= next_sel;
      dout_data  <= next_src[next_sel*WORD_WIDTH +: WORD_WIDTH];
      dout_last  <= next_single;
      if (capture)                       dout_first <= 1'b1;
      else if (handshake || state == IDLE) dout_first <= 1'b0;
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic3_row_readout.sv
// Bench for cic3_row_readout: frame table plus hand-written corner sequences,
// with a beat scoreboard checked by a negedge monitor.
module tb_cic3_row_readout;

  localparam int NF = 24;
  localparam int W  = 25;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sample;
  logic [NF*W-1:0]   filt_in;
  logic [NF-1:0]     ch_mask;
  logic [W-1:0]      dout_data;
  logic [CW-1:0]     dout_ch;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_first;
  logic              dout_last;
  logic              busy;
  logic              overrun;
  logic              clr_overrun;

  cic3_row_readout #(.NUM_FILTERS(NF), .WORD_WIDTH(W), .CH_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sample(sample), .filt_in(filt_in),
    .ch_mask(ch_mask), .dout_data(dout_data), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_first(dout_first),
    .dout_last(dout_last), .busy(busy), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // {ch, data, first, last} packed into 32 bits
  logic [31:0] exp_q[$];

  typedef struct {
    logic [NF-1:0] mask;
    logic [W-1:0]  base;
    bit            toggle;
    int            exp_beats;
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NF*W-1:0] pack_words(input logic [W-1:0] base);
    logic [NF*W-1:0] v;
    for (int k = 0; k < NF; k++) v[k*W +: W] = base + W'(k);
    return v;
  endfunction

  task automatic push_expected(input logic [NF-1:0] mask, input logic [W-1:0] base);
    int first_ch;
    int last_ch;
    first_ch = -1;
    last_ch  = -1;
    for (int k = 0; k < NF; k++) if (mask[k]) begin
      if (first_ch < 0) first_ch = k;
      last_ch = k;
    end
    for (int k = 0; k < NF; k++) if (mask[k])
      exp_q.push_back({CW'(k), base + W'(k), 1'(k == first_ch), 1'(k == last_ch)});
  endtask

  // Beat monitor: scoreboard pop on handshake, stability check while stalled.
  logic        stalled_prev = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    logic [31:0] cur;
    cur = {dout_ch, dout_data, dout_first, dout_last};
    if (reset_n && dout_valid) begin
      if (stalled_prev) check("stall_stable", cur, held);
      if (dout_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", cur, 32'h0);
        else check("beat", cur, exp_q.pop_front());
      end
      stalled_prev = !dout_ready;
      held = cur;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Drive a capture strobe; afterwards scramble filt_in and ch_mask.
  task automatic start_frame(input logic [NF-1:0] mask, input logic [W-1:0] base);
    filt_in = pack_words(base);
    ch_mask = mask;
    sample  = 1'b1;
    push_expected(mask, base);
    @(posedge clk); #1;
    sample  = 1'b0;
    filt_in = pack_words(W'($urandom));
    ch_mask = ~mask;
    check("latency_valid", {31'b0, dout_valid}, 32'd1);
    check("latency_first", {31'b0, dout_first}, 32'd1);
  endtask

  // Run the frame to completion (bounded). drop_at/clr_at pulse sample/clr.
  task automatic finish_frame(input bit toggle, input int exp_beats,
                              input int drop_at, input int clr_at);
    int cyc;
    int vcyc;
    cyc  = 0;
    vcyc = 0;
    while (dout_valid && cyc < 200) begin
      dout_ready  = toggle ? ~cyc[0] : 1'b1;
      sample      = (cyc == drop_at);
      clr_overrun = (cyc == clr_at);
      @(negedge clk);
      vcyc++;
      @(posedge clk); #1;
      sample      = 1'b0;
      clr_overrun = 1'b0;
      cyc++;
    end
    dout_ready = 1'b1;
    check("frame_done", {31'b0, dout_valid}, 32'd0);
    check("busy_idle", {31'b0, busy}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);
    if (!toggle) check("no_bubbles", vcyc, exp_beats);
  endtask

  initial begin
    vecs[0] = '{24'hFFFFFF, 25'h100,     1'b0, 24};
    vecs[1] = '{24'h800005, 25'h200,     1'b1, 3};
    vecs[2] = '{24'h000010, 25'h300,     1'b0, 1};
    vecs[3] = '{24'h5A5A5A, 25'h0ABCDE,  1'b1, 12};
    vecs[4] = '{24'h000001, 25'h0,       1'b0, 1};
    vecs[5] = '{24'h800000, 25'h1FFFF00, 1'b0, 1};

    // 1: reset with sample and ready asserted
    reset_n = 1'b0; sample = 1'b1; dout_ready = 1'b1; clr_overrun = 1'b0;
    ch_mask = '1; filt_in = pack_words(25'h55);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {dout_ch, dout_data, dout_first, dout_last}, 32'h0);
    check("rst_flags", {29'b0, dout_valid, busy, overrun}, 32'h0);
    sample = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {30'b0, dout_valid, busy}, 32'h0);

    // 2/3: table of frames
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].mask, vecs[i].base);
      finish_frame(vecs[i].toggle, vecs[i].exp_beats, -1, -1);
    end
    check("no_overrun", {31'b0, overrun}, 32'd0);

    // 4: drop mid-frame, then clr with simultaneous drop, then clr alone
    start_frame(24'hFFFFFF, 25'h400);
    finish_frame(1'b1, 24, 3, -1);
    check("overrun_set", {31'b0, overrun}, 32'd1);
    start_frame(24'h00FF00, 25'h500);
    finish_frame(1'b0, 8, 2, 2);
    check("overrun_clr_drop", {31'b0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    check("overrun_clr", {31'b0, overrun}, 32'd0);

    // 5: sample on final handshake -> no gap, no overrun
    start_frame(24'h000003, 25'h600);
    @(posedge clk); #1;
    check("b2b_last", {31'b0, dout_last}, 32'd1);
    filt_in = pack_words(25'h700);
    ch_mask = 24'h000C00;
    sample  = 1'b1;
    push_expected(24'h000C00, 25'h700);
    @(posedge clk); #1;
    sample = 1'b0;
    filt_in = '0;
    check("b2b_valid_first", {30'b0, dout_valid, dout_first}, 32'd3);
    check("b2b_ch", dout_ch, 32'd10);
    finish_frame(1'b0, 2, -1, -1);
    check("b2b_no_overrun", {31'b0, overrun}, 32'd0);

    // 5b: sample with empty mask in IDLE is ignored
    ch_mask = '0; sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    check("empty_mask", {29'b0, dout_valid, busy, overrun}, 32'd0);
    @(posedge clk); #1;
    check("empty_mask2", {30'b0, dout_valid, busy}, 32'd0);

    // 6: reset after 5 beats, then restart at ch0
    start_frame(24'hFFFFFF, 25'h800);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_ch", dout_ch, 32'd4);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", {30'b0, dout_valid, busy}, 32'd0);
    check("midrst_last", {31'b0, dout_last}, 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    start_frame(24'hFFFFFF, 25'h900);
    check("restart_ch0", dout_ch, 32'd0);
    finish_frame(1'b0, 24, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
